// File: rtl/lfsr_word_packer.sv
// lfsr_word_packer: packs the LFSR serial bit stream into words and buffers them in a FWFT FIFO.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   bit_in      serial bit from the LFSR
//   bit_en      sample bit_in on this edge
//   clr         synchronous clear of packer, FIFO and overflow (bit_en ignored)
//   word_data   FIFO head word, 0 while empty
//   word_ones   ones-count stored with the head word, 0 while empty
//   word_valid  FIFO not empty
//   word_ready  consumer takes the head on this edge
//   fifo_level  number of buffered words
//   overflow    sticky: a completed word was dropped because the FIFO was full
module lfsr_word_packer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              bit_in,
    input  logic                              bit_en,
    input  logic                              clr,
    output logic [WORD_W-1:0]                 word_data,
    output logic [$clog2(WORD_W+1)-1:0]       word_ones,
    output logic                              word_valid,
    input  logic                              word_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow
);
    localparam int CW = $clog2(WORD_W);
    localparam int OW = $clog2(WORD_W + 1);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [CW-1:0]     cnt;
    logic [OW-1:0]     acc;
    logic [WORD_W-1:0] sr;
    logic [WORD_W-1:0] sr_nxt;
    logic [OW-1:0]     ones_nxt;
    logic              done;
    logic              full;
    logic              pop;
    logic              push;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [WORD_W-1:0] data_mem [FIFO_DEPTH];
    logic [OW-1:0]     ones_mem [FIFO_DEPTH];

    // sr_nxt/ones_nxt already include the current bit, so a completing edge pushes them directly
    assign sr_nxt     = (MSB_FIRST != 0) ? {sr[WORD_W-2:0], bit_in} : {bit_in, sr[WORD_W-1:1]};
    assign ones_nxt   = acc + OW'(bit_in);
    assign done       = bit_en && (cnt == CW'(WORD_W - 1));
    assign word_valid = fifo_level != '0;
    assign full       = fifo_level == LW'(FIFO_DEPTH);
    assign pop        = word_valid && word_ready;
    // a full FIFO still accepts a word when the head leaves on the same edge
    assign push       = done && (!full || pop);
    assign word_data  = word_valid ? data_mem[rptr] : '0;
    assign word_ones  = word_valid ? ones_mem[rptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            acc <= '0;
            sr  <= '0;
        end else if (clr || done) begin
            cnt <= '0;
            acc <= '0;
            sr  <= '0;
        end else if (bit_en) begin
            cnt <= cnt + CW'(1);
            acc <= ones_nxt;
            sr  <= sr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else if (clr) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            wptr       <= wptr + PW'(push);
            rptr       <= rptr + PW'(pop);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            overflow   <= overflow | (done && full && !pop);
        end
    end

    // storage needs no reset: entries are only visible through word_valid
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wptr] <= sr_nxt;
            ones_mem[wptr] <= ones_nxt;
        end
    end
endmodule

// File: tb/tb_lfsr_word_packer.sv
// tb_lfsr_word_packer: scoreboard bench for lfsr_word_packer (MSB-first and LSB-first instances).
module tb_lfsr_word_packer;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic bit_in = 1'b0;
    logic bit_en = 1'b0;
    logic clr = 1'b0;
    logic word_ready = 1'b0;
    logic [W-1:0] d1, d0;
    logic [3:0]   o1, o0;
    logic         v1, v0, ov1, ov0;
    logic [2:0]   l1, l0;

    always #5 clk = ~clk;

    lfsr_word_packer #(.WORD_W(W), .FIFO_DEPTH(D), .MSB_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en), .clr(clr),
        .word_data(d1), .word_ones(o1), .word_valid(v1), .word_ready(word_ready),
        .fifo_level(l1), .overflow(ov1)
    );

    lfsr_word_packer #(.WORD_W(W), .FIFO_DEPTH(D), .MSB_FIRST(0)) u0 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en), .clr(clr),
        .word_data(d0), .word_ones(o0), .word_valid(v0), .word_ready(word_ready),
        .fifo_level(l0), .overflow(ov0)
    );

    typedef struct {
        logic [W-1:0] d;
        logic [3:0]   o;
    } ent_t;

    ent_t q1[$];
    ent_t q0[$];
    bit   bits_m[$];
    bit   ovf_m;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: a pop happens on the coming edge, so compare the head against the oldest expected word
    always @(negedge clk) begin
        ent_t e;
        if (rst && v1 && word_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL u1 unexpected word: got %0h expected none", d1);
            end else begin
                e = q1.pop_front();
                chk("u1 data", d1, e.d);
                chk("u1 ones", o1, e.o);
            end
        end
        if (rst && v0 && word_ready) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL u0 unexpected word: got %0h expected none", d0);
            end else begin
                e = q0.pop_front();
                chk("u0 data", d0, e.d);
                chk("u0 ones", o0, e.o);
            end
        end
    end

    // reference: collect W sampled bits, then form the word arithmetically in both bit orders
    task automatic model(input bit bi, input bit be, input bit rdy, input bit cl);
        ent_t a, b;
        bit   p1, p0;
        if (cl) begin
            q1.delete();
            q0.delete();
            bits_m.delete();
            ovf_m = 1'b0;
            return;
        end
        if (!be) return;
        bits_m.push_back(bi);
        if (bits_m.size() < W) return;
        a.d = '0;
        b.d = '0;
        a.o = '0;
        for (int i = 0; i < W; i++) begin
            a.d = a.d + (W'(bits_m[i]) << (W - 1 - i));
            b.d = b.d + (W'(bits_m[i]) << i);
            a.o = a.o + 4'(bits_m[i]);
        end
        b.o = a.o;
        bits_m.delete();
        p1 = rdy && (q1.size() > 0);
        p0 = rdy && (q0.size() > 0);
        if (q1.size() < D || p1) q1.push_back(a);
        else ovf_m = 1'b1;
        if (q0.size() < D || p0) q0.push_back(b);
        else ovf_m = 1'b1;
    endtask

    task automatic cyc(input bit bi, input bit be, input bit rdy, input bit cl);
        bit r;
        r = cl ? 1'b0 : rdy;
        bit_in = bi;
        bit_en = be;
        word_ready = r;
        clr = cl;
        model(bi, be, r, cl);
        @(posedge clk);
        #2;
        chk("u1 level", l1, q1.size());
        chk("u0 level", l0, q0.size());
        chk("u1 valid", v1, q1.size() > 0);
        chk("u1 overflow", ov1, ovf_m);
        chk("u0 overflow", ov0, ovf_m);
    endtask

    task automatic send_word(input logic [W-1:0] v, input bit rdy, input bit rdy_last, input bit gaps);
        for (int i = 0; i < W; i++) begin
            if (gaps) repeat ($urandom_range(1, 3)) cyc(1'($urandom), 1'b0, rdy, 1'b0);
            cyc(v[W-1-i], 1'b1, (i == W - 1) ? rdy_last : rdy, 1'b0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() > 0 || q0.size() > 0) && n < 50) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        chk("drain left", q1.size() + q0.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst u1 valid", v1, 0);
        chk("rst u1 level", l1, 0);
        chk("rst u1 ovf", ov1, 0);
        chk("rst u1 data", d1, 0);
        chk("rst u1 ones", o1, 0);
        chk("rst u0 valid", v0, 0);
        chk("rst u0 level", l0, 0);
        q1.delete();
        q0.delete();
        bits_m.delete();
        ovf_m = 1'b0;
        bit_en = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        ovf_m = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;

        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        do_reset();
        send_word(8'hFF, 1'b1, 1'b1, 1'b0);
        chk("ff head", d1, 8'hFF);
        chk("ff ones", o1, 8);
        drain();

        send_word(8'hB2, 1'b1, 1'b1, 1'b0);
        chk("b2 valid", v1, 1);
        chk("b2 head", d1, 8'hB2);
        chk("4d head", d0, 8'h4D);
        chk("b2 ones", o1, 4);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2 popped level", l1, 0);

        send_word(8'hB2, 1'b1, 1'b1, 1'b1);
        chk("gap b2 head", d1, 8'hB2);
        chk("gap 4d head", d0, 8'h4D);
        drain();

        for (int v = 1; v <= 5; v++) send_word(W'(v), 1'b0, 1'b0, 1'b0);
        chk("ovf level", l1, 4);
        chk("ovf flag", ov1, 1);
        drain();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        for (int v = 'h11; v <= 'h14; v++) send_word(W'(v), 1'b0, 1'b0, 1'b0);
        send_word(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("5a level", l1, 4);
        chk("5a ovf", ov1, 0);
        drain();

        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr level", l1, 0);
        chk("clr valid", v1, 0);
        send_word(8'h00, 1'b1, 1'b1, 1'b0);
        chk("zero head", d1, 8'h00);
        chk("zero ones", o1, 0);
        drain();

        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            cyc(1'($urandom), ($urandom % 4) != 0,
                (i % 100 < 50) ? (($urandom % 4) == 0) : (($urandom % 4) != 0),
                ($urandom % 97) == 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
